// File: rtl/colorizer_pkg.sv
// Shared colour constants, palette-write FSM states and the reset-default palette function
// for the palette colorizer.
package colorizer_pkg;

  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] GREY  = 8'hDB;
  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;

  typedef enum logic [0:0] {
    PAL_IDLE      = 1'b0,
    PAL_WAIT_DROP = 1'b1
  } pal_state_e;

  // Reset value of palette entry idx; callers truncate to their colour width.
  function automatic logic [31:0] default_entry(input int idx, input int color_w);
    logic [31:0] ones_v;
    ones_v = (color_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << color_w) - 32'd1);
    if (color_w == 8) begin
      case (idx)
        32'sd0:  default_entry = {24'h00_0000, WHITE};
        32'sd1:  default_entry = {24'h00_0000, BLACK};
        32'sd2:  default_entry = {24'h00_0000, RED};
        32'sd3:  default_entry = {24'h00_0000, GREY};
        default: default_entry = 32'h0000_0000;
      endcase
    end else begin
      default_entry = (idx == 32'sd0) ? ones_v : 32'h0000_0000;
    end
  endfunction

endpackage

// File: rtl/icon_priority_mux.sv
// Combinational icon layer select: lowest-index opaque, unsuppressed layer wins.
module icon_priority_mux
  import colorizer_pkg::*;
#(
  parameter int COLOR_W   = 8,
  parameter int NUM_ICONS = 2
) (
  input  logic [NUM_ICONS*COLOR_W-1:0] icon,
  input  logic [NUM_ICONS-1:0]         suppress,
  output logic [COLOR_W-1:0]           color,
  output logic                         hit
);

  logic take_s;

  // Walk from the lowest priority upward so layer 0 is written last and wins.
  always_comb begin
    color  = '0;
    hit    = 1'b0;
    take_s = 1'b0;
    for (int i = NUM_ICONS - 1; i >= 0; i--) begin
      take_s = (icon[i*COLOR_W +: COLOR_W] != '0) && !suppress[i];
      color  = take_s ? icon[i*COLOR_W +: COLOR_W] : color;
      hit    = hit | take_s;
    end
  end

endmodule

// File: rtl/palette_colorizer.sv
// Two-stage palette/icon pixel colorizer with a handshaked palette write port.
// Optional icon blinking is enabled by defining PALETTE_COLORIZER_BLINK_EN.
module palette_colorizer
  import colorizer_pkg::*;
#(
  parameter int COLOR_W      = 8,
  parameter int WORLD_W      = 2,
  parameter int NUM_ICONS    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         video_on,
  input  logic                         frame_tick,
  input  logic [WORLD_W-1:0]           world,
  input  logic [NUM_ICONS*COLOR_W-1:0] icon,
  input  logic [NUM_ICONS-1:0]         icon_blink,
  input  logic                         pal_req,
  input  logic [WORLD_W-1:0]           pal_addr,
  input  logic [COLOR_W-1:0]           pal_data,
  output logic                         pal_ack,
  output logic [COLOR_W-1:0]           color,
  output logic                         video_on_q
);

  localparam int PAL_DEPTH = 2 ** WORLD_W;

  logic [COLOR_W-1:0]   pal_r [PAL_DEPTH];
  pal_state_e           state_r;
  pal_state_e           state_nxt_s;
  logic                 commit_s;
  logic                 pal_ack_r;
  logic [NUM_ICONS-1:0] suppress_s;
  logic [COLOR_W-1:0]   mux_color_s;
  logic                 mux_hit_s;
  logic [COLOR_W-1:0]   pal1_r;
  logic [COLOR_W-1:0]   icon1_r;
  logic                 hit1_r;
  logic                 von1_r;
  logic [COLOR_W-1:0]   color_r;
  logic                 von2_r;

`ifdef PALETTE_COLORIZER_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt_r;
  logic             blink_phase_r;

  // Frame counter: wraps every BLINK_FRAMES ticks and flips the blink phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign suppress_s = blink_phase_r ? icon_blink : '0;
`else
  logic unused_blink_s;
  assign unused_blink_s = ^{icon_blink, frame_tick};
  assign suppress_s     = '0;
`endif

  // Write FSM: one commit per request; stays in WAIT_DROP until pal_req falls.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    case (state_r)
      PAL_IDLE: begin
        if (pal_req && !video_on) begin
          commit_s    = 1'b1;
          state_nxt_s = PAL_WAIT_DROP;
        end else begin
          state_nxt_s = PAL_IDLE;
        end
      end
      PAL_WAIT_DROP: begin
        if (!pal_req) begin
          state_nxt_s = PAL_IDLE;
        end else begin
          state_nxt_s = PAL_WAIT_DROP;
        end
      end
      default: state_nxt_s = PAL_IDLE;
    endcase
  end

  // Write FSM state and acknowledge pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= PAL_IDLE;
      pal_ack_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pal_ack_r <= commit_s;
    end
  end

  // Palette storage; a read on the commit edge still sees the old entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_r[i] <= COLOR_W'(default_entry(i, COLOR_W));
      end
    end else if (commit_s) begin
      pal_r[pal_addr] <= pal_data;
    end
  end

  icon_priority_mux #(
    .COLOR_W   (COLOR_W),
    .NUM_ICONS (NUM_ICONS)
  ) u_icon_mux (
    .icon     (icon),
    .suppress (suppress_s),
    .color    (mux_color_s),
    .hit      (mux_hit_s)
  );

  // Stage 1: palette lookup and icon selection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pal1_r  <= '0;
      icon1_r <= '0;
      hit1_r  <= 1'b0;
      von1_r  <= 1'b0;
    end else begin
      pal1_r  <= pal_r[world];
      icon1_r <= mux_color_s;
      hit1_r  <= mux_hit_s;
      von1_r  <= video_on;
    end
  end

  // Stage 2: blank outside the active area, otherwise icon over palette.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      color_r <= '0;
      von2_r  <= 1'b0;
    end else begin
      color_r <= von1_r ? (hit1_r ? icon1_r : pal1_r) : '0;
      von2_r  <= von1_r;
    end
  end

  assign pal_ack    = pal_ack_r;
  assign color      = color_r;
  assign video_on_q = von2_r;

endmodule

// File: tb/tb_palette_colorizer.sv
// Directed self-checking bench for palette_colorizer (default 8-bit colour, 2 layers).
module tb_palette_colorizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic        frame_tick;
  logic [1:0]  world;
  logic [15:0] icon;
  logic [1:0]  icon_blink;
  logic        pal_req;
  logic [1:0]  pal_addr;
  logic [7:0]  pal_data;
  logic        pal_ack;
  logic [7:0]  color;
  logic        video_on_q;

  int n_tests = 0;
  int n_fail  = 0;

  palette_colorizer #(
    .COLOR_W      (8),
    .WORLD_W      (2),
    .NUM_ICONS    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .world      (world),
    .icon       (icon),
    .icon_blink (icon_blink),
    .pal_req    (pal_req),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .pal_ack    (pal_ack),
    .color      (color),
    .video_on_q (video_on_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pixel(input logic [1:0] w, input logic [15:0] ic, input logic [7:0] exp,
                       input string tag);
    world = w;
    icon  = ic;
    tick();
    tick();
    check(tag, {24'h0, color}, {24'h0, exp});
  endtask

  initial begin
    int acks;
    int post;
    logic [7:0] exp_v;

    reset_n = 1'b0; video_on = 1'b0; frame_tick = 1'b0; world = 2'd0;
    icon = 16'h0000; icon_blink = 2'b00; pal_req = 1'b0; pal_addr = 2'd0; pal_data = 8'h00;
    tick();
    tick();
    check("rst_color", {24'h0, color}, 32'h0);
    check("rst_vq", {31'h0, video_on_q}, 32'h0);
    check("rst_ack", {31'h0, pal_ack}, 32'h0);
    reset_n = 1'b1;

    // Pipelined default palette readout, one pixel per clock.
    video_on = 1'b1;
    world = 2'd0; tick();
    world = 2'd1; tick();
    check("def0", {24'h0, color}, 32'hFF);
    check("def_vq", {31'h0, video_on_q}, 32'h1);
    world = 2'd2; tick();
    check("def1", {24'h0, color}, 32'h00);
    world = 2'd3; tick();
    check("def2", {24'h0, color}, 32'hE0);
    tick();
    check("def3", {24'h0, color}, 32'hDB);

    // Icon priority.
    pixel(2'd2, 16'h031C, 8'h1C, "icon_l0");
    pixel(2'd2, 16'h0300, 8'h03, "icon_l1");
    pixel(2'd2, 16'h0000, 8'hE0, "icon_none");

    // Palette write stalls while video is active.
    pal_req = 1'b1; pal_addr = 2'd2; pal_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ack", {31'h0, pal_ack}, 32'h0);
    end
    video_on = 1'b0;
    tick();
    check("ack_pulse", {31'h0, pal_ack}, 32'h1);
    pal_req = 1'b0;
    tick();
    check("ack_drop", {31'h0, pal_ack}, 32'h0);
    check("blank_color", {24'h0, color}, 32'h0);
    check("blank_vq", {31'h0, video_on_q}, 32'h0);
    video_on = 1'b1;
    pixel(2'd2, 16'h0000, 8'h5A, "wr_5a");

    // Request held past ack: one commit only, later data ignored.
    video_on = 1'b0; pal_req = 1'b1; pal_addr = 2'd1; pal_data = 8'h3C;
    acks = 0; post = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (pal_ack) acks++;
      if (acks > 0) post++;
      if (post == 1) pal_data = 8'h77;
      if (post == 4) pal_req = 1'b0;
    end
    check("one_ack", acks, 32'd1);
    video_on = 1'b1;
    pixel(2'd1, 16'h0000, 8'h3C, "wr_3c");

    // Reset mid-stream with a stalled request pending.
    world = 2'd3; pal_req = 1'b1; pal_addr = 2'd0; pal_data = 8'h11;
    tick();
    reset_n = 1'b0;
    tick();
    check("mrst_color", {24'h0, color}, 32'h0);
    check("mrst_ack", {31'h0, pal_ack}, 32'h0);
    pal_req = 1'b0;
    tick();
    reset_n = 1'b1;
    world = 2'd2;
    tick();
    check("mrst_ack2", {31'h0, pal_ack}, 32'h0);
    check("mrst_lat1", {24'h0, color}, 32'h0);
    tick();
    check("mrst_e2", {24'h0, color}, 32'hE0);
    check("mrst_vq", {31'h0, video_on_q}, 32'h1);
    pixel(2'd1, 16'h0000, 8'h00, "mrst_e1");
    pixel(2'd0, 16'h0000, 8'hFF, "mrst_e0");

    // Blink: layer 0 blinks with a 2-frame half period.
    icon_blink = 2'b01;
    pixel(2'd0, 16'h001C, 8'h1C, "blink_f0");
    for (int f = 1; f < 6; f++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
`ifdef PALETTE_COLORIZER_BLINK_EN
      exp_v = (((f / 2) % 2) == 1) ? 8'hFF : 8'h1C;
`else
      exp_v = 8'h1C;
`endif
      pixel(2'd0, 16'h001C, exp_v, $sformatf("blink_f%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
